// File: rtl/seq_u_arrtm.sv
// Sequential unsigned truncated multiplier using shift-add, one partial-product row per clock.
// Truncated mode multiplies a[N-1:K] * b[N-1:K] and scales the result back by 2K bits.
// Exact mode computes the full N x N product.
module seq_u_arrtm #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           mode_exact,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           out_exact,
  output logic           busy
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  // Index of the last partial-product row in each mode.
  localparam logic [IdxW-1:0] LastExact = IdxW'(N - 1);
  localparam logic [IdxW-1:0] LastTrunc = IdxW'(N - K - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     ta_q, ta_d;
  logic [N-1:0]     tb_q, tb_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic             exact_q, exact_d;
  logic [2*N-1:0]   out_q, out_d;
  logic             out_exact_q, out_exact_d;
  logic [2*N-1:0]   addend;
  logic [2*N-1:0]   acc_sum;
  logic             last_row;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StBusy;
      StBusy:  if (last_row)  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    out       = out_q;
    out_exact = out_exact_q;
  end

  // Current partial-product row added into the accumulator; 2N bits never overflow.
  always_comb begin
    addend   = '0;
    if (tb_q[idx_q]) begin
      addend = {{N{1'b0}}, ta_q} << idx_q;
    end
    acc_sum  = acc_q + addend;
    last_row = (idx_q == last_q);
  end

  // Datapath next-state: latch operands on acceptance, shift-add while busy.
  always_comb begin
    ta_d        = ta_q;
    tb_d        = tb_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    last_d      = last_q;
    exact_d     = exact_q;
    out_d       = out_q;
    out_exact_d = out_exact_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (mode_exact) begin
            ta_d   = a;
            tb_d   = b;
            last_d = LastExact;
          end else begin
            ta_d   = a >> K;
            tb_d   = b >> K;
            last_d = LastTrunc;
          end
          exact_d = mode_exact;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      StBusy: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (last_row) begin
          out_d       = exact_q ? acc_sum : (acc_sum << (2 * K));
          out_exact_d = exact_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_q        <= '0;
      tb_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      exact_q     <= 1'b0;
      out_q       <= '0;
      out_exact_q <= 1'b0;
    end else begin
      ta_q        <= ta_d;
      tb_q        <= tb_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      exact_q     <= exact_d;
      out_q       <= out_d;
      out_exact_q <= out_exact_d;
    end
  end

endmodule
